// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit producing HI/LO results.
//   MULTU/MULT : {hi, lo} = op_a * op_b (shift-add, one multiplier bit per cycle)
//   DIVU/DIV   : lo = quotient, hi = remainder (restoring, one quotient bit per cycle)
// Ports:
//   clk, reset (async, active high), flush (abort in-flight op)
//   start/op/op_a/op_b : request, sampled only when accepted (start & ready & !flush)
//   ready/busy         : idle / operation in flight
//   done               : one-cycle pulse, hi/lo/div_by_zero update with it
//   div_by_zero        : divide had op_b == 0 (lo = all ones, hi = op_a)
//   hi/lo              : results, held until the next done
// Latency: start in cycle 0 -> done in cycle WIDTH+2; ready again in the done cycle.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  // Multiplicand for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  // Multiply: {partial product, remaining multiplier}. Divide: low half is dividend/quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               accept;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               rem_ge;
  logic [WIDTH-1:0]   quo, rem_lo;
  logic               dbz_hit;

  assign ready  = (state_q == StIdle);
  assign busy   = ~ready;
  assign accept = start & ready & ~flush;

  // Sign flags already include signedness of the op, so unsigned ops never fix up.
  assign neg_a = op[0] & op_a[WIDTH-1];
  assign neg_b = op[0] & op_b[WIDTH-1];
  assign mag_a = neg_a ? -op_a : op_a;
  assign mag_b = neg_b ? -op_b : op_b;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign rem_sh   = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, opnd_q});
  assign rem_diff = rem_sh - {1'b0, opnd_q};

  assign quo     = acc_q[WIDTH-1:0];
  assign rem_lo  = rem_q[WIDTH-1:0];
  assign dbz_hit = div_q & (opnd_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StCalc;
          cnt_d    = '0;
          div_d    = op[1];
          sign_a_d = neg_a;
          sign_b_d = neg_b;
          opnd_d   = op[1] ? mag_b : mag_a;
          acc_d    = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
          rem_d    = '0;
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          if (div_q) begin
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], rem_ge};
            rem_d = rem_ge ? rem_diff : rem_sh;
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          done_d = 1'b1;
          if (div_q) begin
            // Divide by zero leaves rem = |op_a|, so the remainder fix restores op_a exactly.
            lo_d  = dbz_hit ? {WIDTH{1'b1}} : ((sign_a_q ^ sign_b_q) ? -quo : quo);
            hi_d  = sign_a_q ? -rem_lo : rem_lo;
            dbz_d = dbz_hit;
          end else begin
            {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative integer multiply/divide unit for the execute stage.
- Next generation of the current mul/div dispatch wrapper: one shared radix-2 datapath replaces the separate mul/div IP instances.
- Adds a start/ready/done handshake, pipeline flush abort, and a defined divide-by-zero result.
- Produces HI/LO register results: multiply gives {hi,lo} = product; divide gives lo = quotient, hi = remainder.

Parameters:
- WIDTH, 32, operand width in bits; legal values are WIDTH >= 4. The product is 2*WIDTH bits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort of the in-flight operation; 1 is valid.
- start  input  1  request; accepted only in a cycle where ready=1.
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- op_a  input  WIDTH  multiplicand or dividend; sampled only on accept.
- op_b  input  WIDTH  multiplier or divisor; sampled only on accept.
- ready  output  1  unit idle, can accept a request.
- busy  output  1  operation in flight (equals !ready).
- done  output  1  one-cycle pulse; hi/lo are updated in the same cycle.
- div_by_zero  output  1  valid with done; 1 when DIV/DIVU had op_b=0.
- hi  output  WIDTH  upper product or remainder; held until the next done.
- lo  output  WIDTH  lower product or quotient; held until the next done.

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, busy=0, done=0, div_by_zero=0, hi=0, lo=0, all internal registers cleared.
- States: IDLE, CALC, FIX.
  - IDLE -> CALC on accept (start & ready & !flush).
  - CALC runs exactly WIDTH cycles on the iteration counter, then -> FIX.
  - FIX -> IDLE always. FIX writes hi/lo and pulses done for one cycle.
- Latency: start high in cycle 0 gives done=1 in cycle WIDTH+2. ready returns to 1 in the done cycle, so back-to-back issue is allowed and a new start may be accepted in the done cycle.
- On accept, register op, the operand signs and the operand magnitudes. Signed ops (MULT, DIV) take the two's-complement magnitude of negative operands; unsigned ops use the operands raw.
- Multiply: shift-add, one multiplier bit per CALC cycle into a 2*WIDTH accumulator. In FIX, negate the product if the op is signed and sign(a) XOR sign(b).
- Divide: restoring division, one quotient bit per CALC cycle using a WIDTH+1-bit partial remainder. In FIX:
  - quotient is negated if the op is signed and the signs differ; truncation is toward zero.
  - remainder is negated if the op is signed and the dividend is negative; the remainder sign follows the dividend.
- Signed overflow, MIN/-1: lo=MIN, hi=0, div_by_zero=0. This wraps naturally through the magnitude path.
- Divide by zero (op_b=0 on DIV/DIVU):
  - Same latency as a normal divide.
  - lo = all ones, hi = op_a exactly as sampled, with no sign fix.
  - div_by_zero=1 in the done cycle.
- div_by_zero is 0 in every done cycle of a multiply. It clears to 0 in the cycle after done.
- start while busy is ignored: no queuing, no effect on the in-flight operation.
- flush=1 in CALC or FIX:
  - next state IDLE; done is not asserted.
  - hi/lo/div_by_zero keep their previous values.
  - ready=1 in the following cycle.
- flush and start in the same cycle: flush wins and start is not accepted.
- flush in IDLE: no effect.
- flush in the FIX cycle suppresses that done and hi/lo update.
- Operands and op are ignored outside the accept cycle and may change freely while busy.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, start in cycle 0 -> done=1 only in cycle 34, hi=0xFFFFFFFE, lo=0x00000001, div_by_zero=0.
- MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 100/7 -> lo=14, hi=2.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 for one cycle. DIV 0xFFFFFFF9/0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF9.
- Flush and busy handling:
  - After a completed op leaving hi=A, lo=B, start DIVU and assert flush in cycle 10 -> no done ever, hi=A, lo=B unchanged, ready=1 in cycle 11.
  - start pulses during busy are ignored.
  - start and flush in the same cycle -> not accepted.
- Reset and width:
  - Assert reset asynchronously mid-CALC -> hi=lo=0, ready=1 immediately, no done.
  - WIDTH=8 instance: MULT 0x80 x 0xFF -> hi=0x00, lo=0x80 in cycle 10.
  - WIDTH=8: back-to-back start in the done cycle is accepted.
